// File: rtl/reg_dump_reader.sv
// Sequential register-file dump engine: walks first..last (wrapping mod 2^ADDR_W)
// through a dedicated read port and streams each value on a valid/ready interface.
module reg_dump_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, address walk and snapshot capture; outputs decoded from next state
  // so every stream/status output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    last_d      = last_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_addr_d = first_addr_i;
          last_d     = last_addr_i;
          state_d    = StRead;
        end
      end
      StRead: begin
        // Captured at the edge ending READ, so a same-edge write is not seen.
        dump_data_d = rd_data_i;
        dump_addr_d = cur_addr_q;
        state_d     = StSend;
      end
      StSend: begin
        if (dump_ready_i) begin
          if (cur_addr_q == last_q) begin
            state_d = StDone;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats a same-cycle handshake: the word in flight is not counted.
    if (abort_i && (state_q != StIdle)) begin
      state_d    = StIdle;
      cur_addr_d = cur_addr_q;
    end

    valid_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  // State and datapath registers with asynchronous reset to an all-zero idle state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      last_q      <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      last_q      <= last_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr_o    = cur_addr_q;
  assign dump_valid_o = valid_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_data_o  = dump_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential read-out engine for the 32 x 32-bit register file. On a start request it walks a range of register addresses through a spare register-file read port. It presents each register's contents on a valid/ready stream to a debug or trace consumer. It is the reader counterpart of the write port driven by the datapath, and it never writes the register file.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width

Ports:
- clk_i  in  1  single clock; all state updates on posedge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a dump; sampled only in IDLE
- first_addr_i  in  ADDR_W  first register of range; latched on accepted start
- last_addr_i  in  ADDR_W  last register of range; latched on accepted start
- abort_i  in  1  synchronous abort of an active dump
- rd_addr_o  out  ADDR_W  address to register-file read port (combinational read, data valid same cycle)
- rd_data_i  in  DATA_W  data returned by register-file read port
- dump_valid_o  out  1  dump word available
- dump_ready_i  in  1  consumer accepts word
- dump_addr_o  out  ADDR_W  register index of current word
- dump_data_o  out  DATA_W  captured register value
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: start_i=1 latches first/last, sets cur_addr=first_addr_i, and moves to READ. Otherwise the FSM stays in IDLE.
- READ: rd_addr_o=cur_addr. rd_data_i is captured into dump_data_o and cur_addr into dump_addr_o. Next state is SEND.
- SEND: dump_valid_o=1 and the outputs are held stable until handshake (dump_valid_o & dump_ready_i).
  - On handshake, if cur_addr==last, the FSM goes to DONE.
  - Otherwise cur_addr increments modulo 2^ADDR_W and the FSM goes to READ.
- DONE: done_o=1 for exactly this cycle, then IDLE.
- Range wraps: if last<first, the sequence runs first..31, 0..last. If first==last, exactly one word is sent. Word count = ((last-first) mod 32)+1.
- Register 0 is read like any other register; no special casing.
- start_i while busy_o=1 is ignored; latched first/last are unchanged.
- abort_i=1 in READ, SEND or DONE forces IDLE on the next edge.
  - dump_valid_o drops and no done_o pulse is produced; a DONE-cycle done_o already asserted still completes.
  - Abort has priority over a same-cycle handshake: that word counts as not transferred.
- Snapshot semantics:
  - Each value is the register contents during its READ cycle.
  - A register-file write to the same address at the edge ending READ is not reflected; the old value is captured.
  - Later writes do not alter a held dump_data_o.
- rd_addr_o outside READ holds cur_addr. The port is a dedicated read port, so its value there is don't-care but stable.

## Timing
- Reset (async, rst_i=1) sets state IDLE, busy_o=0, done_o=0, dump_valid_o=0, rd_addr_o=0, dump_addr_o=0, dump_data_o=0, and clears latched first/last.
- Reset mid-dump aborts immediately with no done pulse. After reset deassertion, the first start is accepted on the first posedge it is sampled high.
- Latency: start_i sampled at edge 0, READ in cycle 1, dump_valid_o high from edge 2.
- Throughput with dump_ready_i held high: one word per 2 cycles. Handshake in cycle n gives the next word valid at cycle n+2.
- Backpressure: dump_valid_o stays high and dump_addr_o/dump_data_o stay constant until accepted; valid never drops without a handshake, except on abort or reset.
- done_o rises one cycle after the final handshake; busy_o falls in the cycle after done_o. A new start_i is accepted in the first IDLE cycle.
- All outputs are registered except rd_addr_o, which comes directly from cur_addr.

## Test plan
- Reset, then preload $r1..$r3=0x11,0x22,0x33; first=1, last=3, ready=1 -> words (1,0x11),(2,0x22),(3,0x33) at 2-cycle spacing; done_o one pulse; busy_o low afterwards.
- Wrap range first=30, last=1 with $r30=0xA, $r31=0xB, $r0=0, $r1=0xC -> addresses 30,31,0,1 in order, 4 words, then done.
- Backpressure: dump_ready_i low for 5 cycles on the first word -> valid, addr and data held constant for all 5 cycles; the word is transferred once, not duplicated.
- Write the register file at address 5 with 0xDEAD at the edge ending READ of addr 5 (old value 0x5) -> 0x5 is dumped; a later read shows 0xDEAD.
- abort_i asserted in SEND of the 2nd word of a 1..4 dump -> IDLE next cycle, valid low, no done_o; a new start with first=last=7 returns one word and done_o.
- rst_i pulsed asynchronously (mid-cycle) during SEND -> all outputs zero immediately, no done_o; start_i while busy ignored (range unchanged, verified by word count).
